// File: rtl/pe_output_drain.sv
// Output drain for a PE: captures N {addr,data} words into a small FIFO and replays them downstream.
// Optional non-monotonic key detection is built when PE_DRAIN_ORDER_CHECK_EN is defined.
module pe_output_drain #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 3,
   parameter int N          = 8,
   parameter int DEPTH      = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_start,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE,
   input  logic                             i_PE_valid,
   output logic                             o_PE_ready,
   output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_data,
   output logic                             o_valid,
   input  logic                             i_ready,
   output logic [$clog2(N+1)-1:0]           o_count,
   output logic                             o_busy,
   output logic                             o_done,
   output logic                             o_order_err
);

   localparam int W  = ADDR_WIDTH + DATA_WIDTH;
   localparam int CW = $clog2(N+1);
   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DRAIN   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]   occ_q, occ_d;
   logic [CW-1:0]   count_q, count_d;
   logic            full_s, empty_s, push_s, pop_s, start_s;

   assign full_s  = (occ_q == OW'(DEPTH));
   assign empty_s = (occ_q == {OW{1'b0}});
   assign start_s = (state_q == S_IDLE) && i_start;
   assign push_s  = (state_q == S_CAPTURE) && !full_s && i_PE_valid;
   assign pop_s   = !empty_s && i_ready;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic; the N-th push moves straight to DRAIN
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (i_start) state_d = S_CAPTURE; else state_d = S_IDLE;
         S_CAPTURE: if (push_s && (count_q == CW'(N-1))) state_d = S_DRAIN; else state_d = S_CAPTURE;
         S_DRAIN:   if (empty_s) state_d = S_DONE; else state_d = S_DRAIN;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      o_PE_ready = (state_q == S_CAPTURE) && !full_s;
      o_busy     = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
      o_done     = (state_q == S_DONE);
      o_valid    = !empty_s;
      if (empty_s) begin
         o_data = {W{1'b0}};
      end else begin
         o_data = mem_q[rd_ptr_q];
      end
   end

   // FIFO pointer, occupancy and word-count next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
      if (start_s) begin
         count_d = {CW{1'b0}};
      end else if (push_s) begin
         count_d = count_q + CW'(1);
      end else begin
         count_d = count_q;
      end
   end

   // FIFO and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         occ_q    <= {OW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         count_q  <= count_d;
      end
   end

   // storage; contents need no reset since o_data is masked while empty
   always_ff @(posedge clk) begin
      if (!rst && push_s) begin
         mem_q[wr_ptr_q] <= i_PE;
      end
   end

   assign o_count = count_q;

`ifdef PE_DRAIN_ORDER_CHECK_EN
   logic [DATA_WIDTH-1:0] prev_q, prev_d;
   logic                  prev_vld_q, prev_vld_d;
   logic                  err_q, err_d;

   // ordering check against the previously accepted key
   always_comb begin
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
      err_d      = err_q;
      if (start_s) begin
         prev_vld_d = 1'b0;
         err_d      = 1'b0;
      end else if (push_s) begin
         prev_d     = i_PE[DATA_WIDTH-1:0];
         prev_vld_d = 1'b1;
         if (prev_vld_q && (i_PE[DATA_WIDTH-1:0] < prev_q)) begin
            err_d = 1'b1;
         end else begin
            err_d = err_q;
         end
      end else begin
         err_d = err_q;
      end
   end

   // ordering check registers
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q     <= {DATA_WIDTH{1'b0}};
         prev_vld_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
         err_q      <= err_d;
      end
   end

   assign o_order_err = err_q;
`else
   assign o_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_pe_output_drain.sv
// Randomised scoreboard bench for pe_output_drain (ADDR_WIDTH=3, DATA_WIDTH=3, N=4, DEPTH=4).
module tb_pe_output_drain;

   localparam int AW = 3;
   localparam int DW = 3;
   localparam int N  = 4;
   localparam int DEPTH = 4;
   localparam int W  = AW + DW;
   localparam int CW = $clog2(N+1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_start = 1'b0;
   logic [W-1:0]  i_PE = '0;
   logic          i_PE_valid = 1'b0;
   logic          o_PE_ready;
   logic [W-1:0]  o_data;
   logic          o_valid;
   logic          i_ready;
   logic [CW-1:0] o_count;
   logic          o_busy;
   logic          o_done;
   logic          o_order_err;

   int checks = 0;
   int fails  = 0;
   bit mon_en = 1'b0;
   int rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random

   // reference model: run phase (0 idle, 1 capture, 2 drain, 3 done), words in flight, counters
   int           ph = 0;
   int           m_count = 0;
   bit           m_err = 1'b0;
   bit           m_pvld = 1'b0;
   int           m_prev = 0;
   logic [W-1:0] exp_q[$];

   pe_output_drain #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_PE(i_PE), .i_PE_valid(i_PE_valid),
      .o_PE_ready(o_PE_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
      .o_count(o_count), .o_busy(o_busy), .o_done(o_done), .o_order_err(o_order_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_err();
`ifdef PE_DRAIN_ORDER_CHECK_EN
      return m_err;
`else
      return 1'b0;
`endif
   endfunction

   // consumer ready driver
   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       i_ready = 1'b0;
         1:       i_ready = 1'b1;
         default: i_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // control checks and model update for the coming edge; accepted words enter the scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         chk("ready", o_PE_ready, (ph == 1) && (exp_q.size() < DEPTH));
         chk("valid", o_valid, exp_q.size() != 0);
         chk("count", o_count, m_count);
         chk("busy", o_busy, (ph == 1) || (ph == 2));
         chk("done", o_done, ph == 3);
         chk("order_err", o_order_err, exp_err());
      end
      if (rst) begin
         ph = 0; m_count = 0; m_err = 1'b0; m_pvld = 1'b0;
         exp_q.delete();
      end else begin
         case (ph)
            0: if (i_start) begin
                  ph = 1; m_count = 0; m_err = 1'b0; m_pvld = 1'b0;
               end
            1: if (i_PE_valid && (exp_q.size() < DEPTH)) begin
                  exp_q.push_back(i_PE);
                  m_count++;
                  if (m_pvld && (int'(i_PE[DW-1:0]) < m_prev)) m_err = 1'b1;
                  m_prev = int'(i_PE[DW-1:0]);
                  m_pvld = 1'b1;
                  if (m_count == N) ph = 2;
               end
            2: if (exp_q.size() == 0) ph = 3;
            default: ph = 0;
         endcase
      end
   end

   // output monitor: every downstream handshake pops and compares the scoreboard head
   always @(negedge clk) begin
      #1;
      if (mon_en && !rst && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL pop_empty: got word %0h expected none at %0t", o_data, $time);
         end else begin
            chk("data", o_data, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] w);
      bit acc = 1'b0;
      int guard = 0;
      i_PE = w;
      i_PE_valid = 1'b1;
      while (!acc && guard < 100) begin
         @(negedge clk);
         acc = o_PE_ready;
         tick();
         guard++;
      end
      i_PE_valid = 1'b0;
      if (!acc) begin
         checks++; fails++;
         $display("FAIL send_timeout: got no accept expected accept of %0h", w);
      end
   endtask

   task automatic wait_done();
      int g = 0;
      while (!o_done && g < 200) begin
         tick();
         g++;
      end
      checks++;
      if (!o_done) begin
         fails++;
         $display("FAIL done_timeout: got o_done=0 expected 1 within 200 cycles");
      end else begin
         tick();
      end
   endtask

   function automatic logic [W-1:0] word(input int key);
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 7));
      return {a, DW'(key)};
   endfunction

   initial begin
      // reset, then valid without start must not be accepted
      rst = 1'b1;
      tick(); tick();
      mon_en = 1'b1;
      chk("rst_data", o_data, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_count", o_count, 0);
      rst = 1'b0;
      i_PE = word(5); i_PE_valid = 1'b1;
      repeat (3) tick();
      chk("idle_ready", o_PE_ready, 0);
      i_PE_valid = 1'b0;

      // ordered run, consumer always ready
      rdy_mode = 1;
      tick();
      start_run();
      send(6'b000_001); send(6'b001_010); send(6'b010_011); send(6'b011_100);
      wait_done();
      chk("run_count", o_count, 4);
      chk("run_err", o_order_err, 0);

      // consumer stalled: FIFO fills, then drains in order
      rdy_mode = 0;
      tick();
      start_run();
      for (int i = 0; i < 4; i++) send(word(i));
      repeat (3) tick();
      chk("full_ready", o_PE_ready, 0);
      chk("full_busy", o_busy, 1);
      rdy_mode = 1;
      wait_done();

      // descending key raises the sticky error; a new start clears it
      start_run();
      send(word(3)); send(word(5)); send(word(2)); send(word(2));
      wait_done();
      chk("err_sticky", o_order_err, exp_err());
      start_run();
      chk("err_clear", o_order_err, 0);
      for (int i = 0; i < 4; i++) send(word(i));
      wait_done();

      // reset in the middle of capture, then a clean run
      rdy_mode = 0;
      tick();
      start_run();
      send(word(1)); send(word(2));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", o_valid, 0);
      chk("mid_rst_count", o_count, 0);
      chk("mid_rst_busy", o_busy, 0);
      rdy_mode = 1;
      tick();
      start_run();
      for (int i = 0; i < 4; i++) send(word(i + 2));
      wait_done();
      chk("post_rst_count", o_count, 4);

      // start pulses during capture and drain are ignored
      rdy_mode = 0;
      tick();
      start_run();
      send(word(1)); send(word(1));
      start_run();
      send(word(4)); send(word(6));
      start_run();
      rdy_mode = 1;
      wait_done();
      chk("ign_count", o_count, 4);

      // random runs with random gaps and random consumer back-pressure
      rdy_mode = 2;
      for (int r = 0; r < 10; r++) begin
         start_run();
         for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(word(int'($urandom_range(0, 7))));
         end
         wait_done();
         repeat ($urandom_range(0, 3)) tick();
      end

      rdy_mode = 1;
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish within 500000");
      $fatal(1, "watchdog");
   end

endmodule
